// File: rtl/nrow_game_engine.sv
// nrow_game_engine: N-in-a-row board game core (ROWS x COLS board, WIN_LEN run wins).
// Moves arrive over a valid/ready handshake. Each move is validated, the stone is placed,
// and a neighbour scan then walks one cell per cycle in four directions to find a win or a draw.
// Optional feature: define NROW_UNDO_EN to add one-level undo (undo_req / undo_ack).
// Ports:
//   clk, rst (async, active-high)       clock and reset
//   start                               clear the board and begin a game; X moves first
//   mv_valid/mv_ready/mv_idx            move request handshake; mv_idx is row-major
//   mv_resp_valid/mv_resp_code          one-cycle response: 00 ok, 01 occupied, 10 range, 11 over
//   rd_idx/rd_cell                      combinational board read port for the display
//   turn_o, result, moves_cnt, busy     game status
//   undo_req/undo_ack                   one-level undo (only when NROW_UNDO_EN is defined)
module nrow_game_engine #(
    parameter int unsigned ROWS    = 3,
    parameter int unsigned COLS    = 3,
    parameter int unsigned WIN_LEN = 3,
    parameter int unsigned IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mv_valid,
    output logic             mv_ready,
    input  logic [IDX_W-1:0] mv_idx,
    output logic             mv_resp_valid,
    output logic [1:0]       mv_resp_code,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cell,
    output logic             turn_o,
    output logic [1:0]       result,
    output logic [IDX_W:0]   moves_cnt,
    output logic             busy
`ifdef NROW_UNDO_EN
    ,
    input  logic             undo_req,
    output logic             undo_ack
`endif
);

    localparam int unsigned CELLS  = ROWS * COLS;
    localparam int unsigned CELL_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned MAXD   = (ROWS > COLS) ? ROWS : COLS;
    localparam int unsigned RC_W   = $clog2(MAXD) + 1;
    localparam int unsigned STEP_W = $clog2(WIN_LEN);
    localparam int unsigned RUN_W  = $clog2(2 * WIN_LEN) + 1;
    localparam int unsigned CNT_W  = IDX_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_PLACE, S_CHECK, S_RESP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          board_q [CELLS];
    logic [1:0]          board_d [CELLS];
    logic                turn_q, turn_d;
    logic [1:0]          result_q, result_d;
    logic [CNT_W-1:0]    moves_q, moves_d;
    logic                rv_q, rv_d, ready_q, ready_d, busy_q, busy_d;
    logic [1:0]          code_q, code_d;
    logic [CELL_W-1:0]   idx_q, idx_d;
    logic [RC_W-1:0]     r0_q, r0_d, c0_q, c0_d;
    logic [1:0]          dir_q, dir_d;
    logic                side_q, side_d, alive_q, alive_d, win_q, win_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [RUN_W-1:0]    run_q, run_d;
`ifdef NROW_UNDO_EN
    logic                hist_v_q, hist_v_d, hist_col_q, hist_col_d, ack_q, ack_d;
`endif

    logic [1:0]          probe_cell, colour;
    logic [RUN_W-1:0]    run_base, run_nx;
    logic                match, last_step, hit;

    // Neighbour probe for the current scan step, computed on (row, col) so runs never wrap.
    always_comb begin
        int dr, dc, sgn, pr, pc;
        dr = 0;
        dc = 1;
        case (dir_q)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        sgn = side_q ? -1 : 1;
        pr  = int'(r0_q) + sgn * dr * (int'(step_q) + 1);
        pc  = int'(c0_q) + sgn * dc * (int'(step_q) + 1);
        probe_cell = 2'b00;
        if (pr >= 0 && pr < int'(ROWS) && pc >= 0 && pc < int'(COLS))
            probe_cell = board_q[CELL_W'(pr * int'(COLS) + pc)];
    end

    // Run accumulation: run restarts at 1 per direction, counting stops per side on a mismatch.
    always_comb begin
        colour    = turn_q ? 2'b10 : 2'b01;
        run_base  = (!side_q && step_q == '0) ? RUN_W'(1) : run_q;
        match     = ((step_q == '0) || alive_q) && (probe_cell == colour);
        run_nx    = run_base + RUN_W'(match);
        last_step = (step_q == STEP_W'(WIN_LEN - 2));
        hit       = (run_nx >= RUN_W'(WIN_LEN));
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        result_d = result_q;
        moves_d  = moves_q;
        rv_d     = 1'b0;
        code_d   = 2'b00;
        idx_d    = idx_q;
        r0_d     = r0_q;
        c0_d     = c0_q;
        dir_d    = dir_q;
        side_d   = side_q;
        step_d   = step_q;
        run_d    = run_q;
        alive_d  = alive_q;
        win_d    = win_q;
`ifdef NROW_UNDO_EN
        hist_v_d   = hist_v_q;
        hist_col_d = hist_col_q;
        ack_d      = 1'b0;
`endif
        if (start) begin
            board_d  = '{default: 2'b00};
            turn_d   = 1'b0;
            result_d = 2'b00;
            moves_d  = '0;
            state_d  = S_PLAY;
`ifdef NROW_UNDO_EN
            hist_v_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_PLAY, S_DONE: begin
`ifdef NROW_UNDO_EN
                    if (undo_req && hist_v_q) begin
                        board_d[idx_q] = 2'b00;
                        moves_d  = moves_q - CNT_W'(1);
                        turn_d   = hist_col_q;
                        result_d = 2'b00;
                        state_d  = S_PLAY;
                        ack_d    = 1'b1;
                        hist_v_d = 1'b0;
                    end else
`endif
                    if (mv_valid) begin
                        rv_d = 1'b1;
                        if (state_q == S_DONE) begin
                            code_d = 2'b11;
                        end else if (32'(mv_idx) >= CELLS) begin
                            code_d = 2'b10;
                        end else if (board_q[CELL_W'(mv_idx)] != 2'b00) begin
                            code_d = 2'b01;
                        end else begin
                            rv_d    = 1'b0;
                            idx_d   = CELL_W'(mv_idx);
                            r0_d    = RC_W'(32'(mv_idx) / COLS);
                            c0_d    = RC_W'(32'(mv_idx) % COLS);
                            state_d = S_PLACE;
                        end
                    end
                end
                S_PLACE: begin
                    board_d[idx_q] = colour;
                    moves_d = moves_q + CNT_W'(1);
                    dir_d   = 2'd0;
                    side_d  = 1'b0;
                    step_d  = '0;
                    win_d   = 1'b0;
                    state_d = S_CHECK;
`ifdef NROW_UNDO_EN
                    hist_v_d   = 1'b1;
                    hist_col_d = turn_q;
`endif
                end
                S_CHECK: begin
                    run_d   = run_nx;
                    alive_d = match;
                    win_d   = win_q | hit;
                    if (last_step) begin
                        step_d = '0;
                        side_d = ~side_q;
                        if (side_q) dir_d = dir_q + 2'd1;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                    if (last_step && side_q && dir_q == 2'd3) begin
                        rv_d    = 1'b1;
                        state_d = S_RESP;
                        if (win_q | hit)            result_d = colour;
                        else if (32'(moves_q) == CELLS) result_d = 2'b11;
                        else                        result_d = 2'b00;
                    end
                end
                S_RESP: begin
                    if (result_q == 2'b00) begin
                        turn_d  = ~turn_q;
                        state_d = S_PLAY;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
        ready_d = (state_d == S_PLAY) || (state_d == S_DONE);
        busy_d  = (state_d == S_PLACE) || (state_d == S_CHECK) || (state_d == S_RESP);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            board_q  <= '{default: 2'b00};
            turn_q   <= 1'b0;
            result_q <= 2'b00;
            moves_q  <= '0;
            rv_q     <= 1'b0;
            code_q   <= 2'b00;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            r0_q     <= '0;
            c0_q     <= '0;
            dir_q    <= '0;
            side_q   <= 1'b0;
            step_q   <= '0;
            run_q    <= '0;
            alive_q  <= 1'b0;
            win_q    <= 1'b0;
`ifdef NROW_UNDO_EN
            hist_v_q   <= 1'b0;
            hist_col_q <= 1'b0;
            ack_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            result_q <= result_d;
            moves_q  <= moves_d;
            rv_q     <= rv_d;
            code_q   <= code_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            idx_q    <= idx_d;
            r0_q     <= r0_d;
            c0_q     <= c0_d;
            dir_q    <= dir_d;
            side_q   <= side_d;
            step_q   <= step_d;
            run_q    <= run_d;
            alive_q  <= alive_d;
            win_q    <= win_d;
`ifdef NROW_UNDO_EN
            hist_v_q   <= hist_v_d;
            hist_col_q <= hist_col_d;
            ack_q      <= ack_d;
`endif
        end
    end

    // Display read port, zero outside the board.
    always_comb begin
        rd_cell = 2'b00;
        if (32'(rd_idx) < CELLS) rd_cell = board_q[CELL_W'(rd_idx)];
    end

    assign mv_ready      = ready_q;
    assign mv_resp_valid = rv_q;
    assign mv_resp_code  = code_q;
    assign turn_o        = turn_q;
    assign result        = result_q;
    assign moves_cnt     = moves_q;
    assign busy          = busy_q;
`ifdef NROW_UNDO_EN
    assign undo_ack      = ack_q;
`endif

endmodule

// File: tb/tb_nrow_game_engine.sv
// tb_nrow_game_engine: random and directed games on a 3x3 and a 4x4 instance (WIN_LEN=3),
// compared against a board-level reference model that scans the whole board for lines.
module tb_nrow_game_engine;

    localparam int W   = 3;
    localparam int LAT = 8 * (W - 1) + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_r [2];
    logic       valid_r [2];
    logic [3:0] idx_r   [2];
    logic [3:0] rdi_r   [2];
    logic       rdy     [2];
    logic       rv      [2];
    logic       turn    [2];
    logic       busy    [2];
    logic [1:0] code    [2];
    logic [1:0] rc      [2];
    logic [1:0] res     [2];
    logic [4:0] mc      [2];
`ifdef NROW_UNDO_EN
    logic       undo_r  [2];
    logic       ack     [2];
`endif

    always #5 clk = ~clk;

    nrow_game_engine #(.ROWS(3), .COLS(3), .WIN_LEN(3), .IDX_W(4)) dut3 (
        .clk(clk), .rst(rst), .start(start_r[0]), .mv_valid(valid_r[0]), .mv_ready(rdy[0]),
        .mv_idx(idx_r[0]), .mv_resp_valid(rv[0]), .mv_resp_code(code[0]), .rd_idx(rdi_r[0]),
        .rd_cell(rc[0]), .turn_o(turn[0]), .result(res[0]), .moves_cnt(mc[0]), .busy(busy[0])
`ifdef NROW_UNDO_EN
        , .undo_req(undo_r[0]), .undo_ack(ack[0])
`endif
    );

    nrow_game_engine #(.ROWS(4), .COLS(4), .WIN_LEN(3), .IDX_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_r[1]), .mv_valid(valid_r[1]), .mv_ready(rdy[1]),
        .mv_idx(idx_r[1]), .mv_resp_valid(rv[1]), .mv_resp_code(code[1]), .rd_idx(rdi_r[1]),
        .rd_cell(rc[1]), .turn_o(turn[1]), .result(res[1]), .moves_cnt(mc[1]), .busy(busy[1])
`ifdef NROW_UNDO_EN
        , .undo_req(undo_r[1]), .undo_ack(ack[1])
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: board contents, player to move, result, stone count.
    int mb [16];
    int m_turn, m_res, m_moves, R, C;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset(input int s);
        R = (s != 0) ? 4 : 3;
        C = R;
        for (int i = 0; i < 16; i++) mb[i] = 0;
        m_turn  = 0;
        m_res   = 0;
        m_moves = 0;
    endfunction

    // True when any straight line of W cells on the board holds colour col.
    function automatic bit model_win(input int col);
        int dr [4];
        int dc [4];
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok;
                    ok = 1'b1;
                    for (int k = 0; k < W; k++) begin
                        int rr, cc;
                        rr = r + dr[d] * k;
                        cc = c + dc[d] * k;
                        if (rr < 0 || rr >= R || cc < 0 || cc >= C) ok = 1'b0;
                        else if (mb[rr * C + cc] != col) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic check_state(input int s);
        check("result", int'(res[s]), m_res);
        check("turn", int'(turn[s]), m_turn);
        check("moves_cnt", int'(mc[s]), m_moves);
        for (int i = 0; i < 16; i++) begin
            rdi_r[s] = 4'(i);
            #1;
            check($sformatf("cell%0d", i), int'(rc[s]), (i < R * C) ? mb[i] : 0);
        end
        @(negedge clk);
    endtask

    task automatic do_start(input int s);
        start_r[s] = 1'b1;
        @(negedge clk);
        start_r[s] = 1'b0;
        model_reset(s);
        check("start_ready", int'(rdy[s]), 1);
        check_state(s);
    endtask

    task automatic do_move(input int s, input int idx);
        int n, exp_code, col;
        n = 0;
        while (!rdy[s] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", int'(rdy[s]), 1);
        if (m_res != 0)          exp_code = 3;
        else if (idx >= R * C)   exp_code = 2;
        else if (mb[idx] != 0)   exp_code = 1;
        else                     exp_code = 0;
        idx_r[s]   = 4'(idx);
        valid_r[s] = 1'b1;
        @(negedge clk);
        valid_r[s] = 1'b0;
        if (exp_code != 0) begin
            check("resp_valid_t1", int'(rv[s]), 1);
        end else begin
            n = 0;
            while (!rv[s] && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("resp_latency", n, LAT - 1);
            col = m_turn + 1;
            mb[idx] = col;
            m_moves++;
            if (model_win(col))      m_res = col;
            else if (m_moves == R * C) m_res = 3;
            check("resp_result", int'(res[s]), m_res);
        end
        check("resp_code", int'(code[s]), exp_code);
        @(negedge clk);
        check("resp_strobe_len", int'(rv[s]), 0);
        if (exp_code == 0 && m_res == 0) m_turn ^= 1;
        check_state(s);
    endtask

    initial begin
        int n;
        int seq4 [9];
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_r[s] = 1'b0;
            valid_r[s] = 1'b0;
            idx_r[s]   = 4'd0;
            rdi_r[s]   = 4'd0;
`ifdef NROW_UNDO_EN
            undo_r[s]  = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            model_reset(s);
            check("rst_ready", int'(rdy[s]), 0);
            check("rst_busy", int'(busy[s]), 0);
            check("rst_resp_valid", int'(rv[s]), 0);
            check_state(s);
        end
        rst = 1'b0;
        @(negedge clk);

        // IDLE ignores moves.
        valid_r[0] = 1'b1;
        idx_r[0]   = 4'd0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (rv[0] || rdy[0]) n++;
        end
        valid_r[0] = 1'b0;
        check("idle_ignore", n, 0);

        // X wins across the top row.
        do_start(0);
        do_move(0, 0); do_move(0, 3); do_move(0, 1); do_move(0, 4); do_move(0, 2);
        check("t1_x_wins", int'(res[0]), 1);

        // Occupied cell.
        do_start(0);
        do_move(0, 4); do_move(0, 4);

        // Out of range.
        do_start(0);
        do_move(0, 9); do_move(0, 15);

        // Draw, then a move after game over.
        do_start(0);
        seq4 = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        for (int i = 0; i < 9; i++) do_move(0, seq4[i]);
        check("t4_draw", int'(res[0]), 3);
        do_move(0, 0);

        // 4x4: a run crossing the row 0/1 boundary is not a win.
        do_start(1);
        do_move(1, 2); do_move(1, 8); do_move(1, 3); do_move(1, 9); do_move(1, 4);
        check("t5_no_wrap_win", int'(res[1]), 0);

        // start during CHECK aborts the move.
        do_start(0);
        idx_r[0]   = 4'd4;
        valid_r[0] = 1'b1;
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (6) @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        model_reset(0);
        n = 0;
        repeat (30) begin
            if (rv[0]) n++;
            @(negedge clk);
        end
        check("abort_no_resp", n, 0);
        check("abort_ready", int'(rdy[0]), 1);
        check("abort_busy", int'(busy[0]), 0);
        check_state(0);

`ifdef NROW_UNDO_EN
        do_start(0);
        do_move(0, 4);
        undo_r[0] = 1'b1;
        @(negedge clk);
        undo_r[0] = 1'b0;
        check("undo_ack", int'(ack[0]), 1);
        mb[4] = 0;
        m_moves--;
        m_turn = 0;
        check_state(0);
        undo_r[0] = 1'b1;
        @(negedge clk);
        undo_r[0] = 1'b0;
        check("undo_second_ack", int'(ack[0]), 0);
        check_state(0);
`endif

        // Random games on both boards.
        for (int g = 0; g < 10; g++) begin
            int s;
            s = g % 2;
            do_start(s);
            for (int m = 0; m < 40 && m_res == 0; m++)
                do_move(s, (s != 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 11)));
            do_move(s, int'($urandom_range(0, 15)));
        end

        // Reset mid-operation.
        do_start(0);
        idx_r[0]   = 4'd5;
        valid_r[0] = 1'b1;
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset(0);
        check("midrst_ready", int'(rdy[0]), 0);
        check("midrst_busy", int'(busy[0]), 0);
        check("midrst_resp_valid", int'(rv[0]), 0);
        check_state(0);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
